// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Conditions raw board buttons and switches before they reach the record and
// playback control FSMs. Each channel is handled independently:
//   1. a SYNC_STAGES-deep synchronizer chain,
//   2. a stability-counter debouncer that accepts a new value only after it
//      has held for DEBOUNCE_CYCLES consecutive clocks,
//   3. a registered debounced level,
//   4. registered one-clock edge pulses (rise always; fall optionally).
// A single 'changed' pulse flags any accepted change on any channel.
//
// Optional feature macro: INPUT_COND_FALL_EDGE_EN
//   defined   -> 'fall' port exists and pulses on accepted 1->0 changes
//   undefined -> no 'fall' port and no fall logic; 'changed' still pulses
//                on 1->0 accepts
//
// Parameters:
//   CHANNELS        number of independent input channels
//   SYNC_STAGES     synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES clocks a new value must hold before acceptance (>= 1)
//   RESET_VALUE     value of synchronizer flops and level during reset
//
// Ports:
//   clock    in   1         system clock, rising edge
//   reset    in   1         asynchronous active-low reset
//   din      in   CHANNELS  raw asynchronous inputs
//   level    out  CHANNELS  debounced, synchronized level
//   rise     out  CHANNELS  one-clock pulse on accepted 0->1
//   changed  out  1         one-clock pulse when any level bit changes
//   fall     out  CHANNELS  one-clock pulse on accepted 1->0 (macro only)
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int                  CHANNELS        = 5,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic                changed
`ifdef INPUT_COND_FALL_EDGE_EN
    ,
    output logic [CHANNELS-1:0] fall
`endif
);

    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // r_sync[0] samples din; r_sync[SYNC_STAGES-1] is the only stage used
    // downstream.
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CHANNELS-1:0]                  r_level;
    logic [CNT_W-1:0]                     r_cnt [CHANNELS];
    logic [CHANNELS-1:0]                  r_rise;
    logic                                 r_changed;
`ifdef INPUT_COND_FALL_EDGE_EN
    logic [CHANNELS-1:0]                  r_fall;
`endif

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_accept;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A channel is accepted when it has disagreed with level for the full
    // debounce window; the counter is cleared on any agreement, so reaching
    // CNT_MAX implies DEBOUNCE_CYCLES consecutive mismatching clocks.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_accept[i] = (w_s[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Synchronizer chain. Loading RESET_VALUE keeps the chain consistent
    // with level so reset release cannot fabricate an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce counters and debounced level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= RESET_VALUE;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_s[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_level[i] <= w_s[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge pulses, registered so they coincide with the level update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rise    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_rise    <= w_accept & w_s;
            r_changed <= |w_accept;
        end
    end

`ifdef INPUT_COND_FALL_EDGE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fall <= '0;
        end else begin
            r_fall <= w_accept & ~w_s;
        end
    end

    assign fall = r_fall;
`endif

    assign level   = r_level;
    assign rise    = r_rise;
    assign changed = r_changed;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the fixed 5-bit two-flop button/switch synchronizer.
- Sits between the board buttons/switches (reset, record, play, clip-select) and the record/playback control FSMs.
- Per channel: an N-stage synchronizer, a stability-counter debouncer, a registered debounced level, and a one-cycle rising-edge pulse, so control logic no longer hand-builds edge detectors.

Parameters:
- CHANNELS, 5, number of independent input channels.
- SYNC_STAGES, 2, synchronizer flop depth; legal values are 2 or more.
- DEBOUNCE_CYCLES, 16, consecutive clocks an input must hold a new value before it is accepted; legal values are 1 or more.
- RESET_VALUE, {CHANNELS{1'b0}}, value loaded into the synchronizer flops and into level during reset.

Ports:
- clock  in  1  system clock; all flops are on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserts immediately and is released synchronously by the system.
- din  in  CHANNELS  raw asynchronous button/switch inputs.
- level  out  CHANNELS  debounced, synchronized level.
- rise  out  CHANNELS  one-clock pulse when level goes 0->1 on that channel.
- changed  out  1  one-clock pulse when any level bit changed this cycle.
- fall  out  CHANNELS  one-clock pulse when level goes 1->0; present only with INPUT_COND_FALL_EDGE_EN.

Behaviour:
- Reset (reset=0), asynchronous:
  - all synchronizer flops <= RESET_VALUE;
  - level <= RESET_VALUE;
  - all debounce counters <= 0;
  - rise, fall and changed <= 0.
  - Loading the synchronizer with RESET_VALUE prevents a spurious edge when reset releases.
- Synchronizer: din feeds a SYNC_STAGES-deep shift chain per bit; s = the last stage. Nothing downstream uses din or any earlier stage.
- Debounce, per channel i, each rising edge:
  - s[i]==level[i]: cnt[i] <= 0.
  - s[i]!=level[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i]!=level[i] and cnt[i]==DEBOUNCE_CYCLES-1: level[i] <= s[i], cnt[i] <= 0.
- Counter width is $clog2(DEBOUNCE_CYCLES+1), with a minimum of 1. The counter never wraps; it is always cleared on accept or on mismatch loss.
- Latency: if din[i] changes between edges 0 and 1 and then holds, level[i] updates on edge SYNC_STAGES+DEBOUNCE_CYCLES. With the defaults that is edge 18.
- Glitch rejection: any excursion of s[i] shorter than DEBOUNCE_CYCLES clocks clears cnt[i] on return, and level[i] does not change.
- Pulses, registered:
  - rise[i] <= the accept condition AND s[i]==1.
  - fall[i] <= the accept condition AND s[i]==0.
  - changed <= OR over all channels of the accept condition.
  - Each pulse is high for exactly one clock, on the same edge level updates. Because accept also clears cnt[i], two pulses on one channel are at least DEBOUNCE_CYCLES clocks apart.
- Channels are fully independent. Simultaneous accepts on several channels assert their rise/fall bits in the same cycle, with a single changed pulse.
- Reset mid-operation: partial counts are discarded and level returns to RESET_VALUE. No pulse is generated by reset entry or by reset release. After release the input must satisfy the full latency again.
- DEBOUNCE_CYCLES=1 degenerates to synchronizer plus a change register; latency is SYNC_STAGES+1.

Optional Feature:
- Macro: INPUT_COND_FALL_EDGE_EN.
- Defined: the fall port exists and pulses per the rule above.
- Undefined:
  - the fall port is absent and no fall logic is synthesized;
  - rise, level and changed are unaffected;
  - changed still pulses on 1->0 accepts.

Test Plan (CHANNELS=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock, edge 0 = last edge before the din change):
- Reset hold: reset=0 with din=5'b11111 for 10 clocks -> level=5'b00000, rise=0, changed=0; release with din still 11111 -> level=11111 at edge 6 after release, rise=11111 and changed=1 for exactly one cycle.
- Clean press: din 00000->01000 -> level[3]=1 at edge 6, rise=01000 and changed=1 for one cycle only, other bits 0.
- Bounce reject: din[1] high 3 clocks, low 1, high 2, low -> level stays 00000, no rise/changed; then din[1] high 10 clocks -> exactly one rise[1] pulse.
- Simultaneous: din 00000->10101 -> rise=10101 in a single cycle at edge 6, changed high one cycle.
- Reset mid-debounce: din[0]=1, reset=0 at edge 4 for 2 clocks, then released with din[0] still 1 -> no rise before reset; rise[0] at edge 6 after release; level[0]=1.
- Release (with macro): from level=01000, din->00000 -> level=00000 at edge 6, fall=01000 one cycle, rise=0; without macro, changed still pulses at edge 6.
